// File: rtl/writeback_buf.sv
// writeback_buf: circular buffer of evicted dirty cache blocks waiting to be
// written to memory.
//   - Write side  : wr_valid/wr_addr/wr_data in, wr_ready out. A write whose
//                   block tag matches a buffered entry that is not currently
//                   being written to memory is merged into that entry (coalescing).
//   - Read side   : rd_addr in, fwd_hit/fwd_data out. This is a combinational
//                   lookup that returns the youngest matching entry.
//   - Memory side : mem_req/mem_addr/mem_wdata out, mem_ack in. Requests are
//                   registered and stay stable until mem_ack is seen.
//   - Control     : flush in (blocks new writes while draining), busy out.
// Reset is asynchronous and active-high.
module writeback_buf #(
    parameter  int unsigned DEPTH   = 4,
    localparam int unsigned WORD_W  = 32,
    localparam int unsigned BLOCK_W = 256,
    localparam int unsigned OFF_W   = 5,
    localparam int unsigned TAG_W   = WORD_W - OFF_W,
    localparam int unsigned PTR_W   = $clog2(DEPTH),
    localparam int unsigned CNT_W   = PTR_W + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_valid,
    input  logic [WORD_W-1:0]  wr_addr,
    input  logic [BLOCK_W-1:0] wr_data,
    output logic               wr_ready,
    input  logic [WORD_W-1:0]  rd_addr,
    output logic               fwd_hit,
    output logic [BLOCK_W-1:0] fwd_data,
    output logic               mem_req,
    output logic [WORD_W-1:0]  mem_addr,
    output logic [BLOCK_W-1:0] mem_wdata,
    input  logic               mem_ack,
    input  logic               flush,
    output logic               busy
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_WRITE = 1'b1
    } state_e;

    state_e               state_q;
    logic [CNT_W-1:0]     count_q;
    logic [PTR_W-1:0]     head_q;
    logic [PTR_W-1:0]     tail_q;
    logic [DEPTH-1:0]     valid_q;
    logic [TAG_W-1:0]     tag_q  [DEPTH];
    logic [BLOCK_W-1:0]   data_q [DEPTH];
    logic                 mem_req_q;
    logic [WORD_W-1:0]    mem_addr_q;
    logic [BLOCK_W-1:0]   mem_wdata_q;

    logic [TAG_W-1:0]     wr_tag;
    logic [TAG_W-1:0]     rd_tag;
    logic                 coal_hit;
    logic [PTR_W-1:0]     coal_idx;
    logic                 accept;
    logic                 do_coal;
    logic                 do_push;
    logic                 do_pop;
    logic                 lk_hit;
    logic [BLOCK_W-1:0]   lk_data;
    logic [PTR_W-1:0]     lk_idx;
    logic [2*OFF_W-1:0]   unused_offset_bits;

    assign wr_tag = wr_addr[WORD_W-1:OFF_W];
    assign rd_tag = rd_addr[WORD_W-1:OFF_W];
    assign unused_offset_bits = {wr_addr[OFF_W-1:0], rd_addr[OFF_W-1:0]};

    // Coalesce target: a valid entry with the same tag, except the head while
    // memory is writing it. Allocation rules keep at most one such entry.
    always_comb begin
        coal_hit = 1'b0;
        coal_idx = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (tag_q[i] == wr_tag) &&
                !((state_q == S_WRITE) && (PTR_W'(i) == head_q))) begin
                coal_hit = 1'b1;
                coal_idx = PTR_W'(i);
            end
        end
    end

    assign wr_ready = !flush && ((count_q < CNT_W'(DEPTH)) || coal_hit);
    assign accept   = wr_valid && wr_ready;
    assign do_coal  = accept && coal_hit;
    assign do_push  = accept && !coal_hit;
    assign do_pop   = (state_q == S_WRITE) && mem_ack;

    // Forwarding: walk entries from oldest to youngest so the last match wins.
    always_comb begin
        lk_hit  = 1'b0;
        lk_data = '0;
        lk_idx  = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            lk_idx = head_q + PTR_W'(k);
            if ((CNT_W'(k) < count_q) && valid_q[lk_idx] && (tag_q[lk_idx] == rd_tag)) begin
                lk_hit  = 1'b1;
                lk_data = data_q[lk_idx];
            end
        end
    end

    assign fwd_hit   = lk_hit;
    assign fwd_data  = lk_data;
    assign busy      = (count_q != '0) || (state_q == S_WRITE);
    assign mem_req   = mem_req_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

    // Entry storage, pointers and the drain FSM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            count_q     <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            valid_q     <= '0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                tag_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else begin
            if (do_coal) begin
                data_q[coal_idx] <= wr_data;
            end
            if (do_push) begin
                tag_q[tail_q]   <= wr_tag;
                data_q[tail_q]  <= wr_data;
                valid_q[tail_q] <= 1'b1;
                tail_q          <= tail_q + PTR_W'(1);
            end
            if (do_pop) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase

            case (state_q)
                S_IDLE: begin
                    if (count_q != '0) begin
                        state_q    <= S_WRITE;
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= {tag_q[head_q], OFF_W'(0)};
                        // A write merging into the head on this same edge must
                        // reach memory, so take it instead of the stale copy.
                        mem_wdata_q <= (do_coal && (coal_idx == head_q)) ? wr_data
                                                                         : data_q[head_q];
                    end
                end
                S_WRITE: begin
                    if (mem_ack) begin
                        state_q   <= S_IDLE;
                        mem_req_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= S_IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_writeback_buf.sv
// Testbench for writeback_buf. The reference model is a queue of pending blocks
// with an "in flight" flag on the head. Every memory write the model starts is
// pushed to a scoreboard, and a monitor compares that scoreboard against the
// DUT's memory port.
module tb_writeback_buf;

    localparam int unsigned DEPTH = 4;

    logic         clk;
    logic         rst;
    logic         wr_valid;
    logic [31:0]  wr_addr;
    logic [255:0] wr_data;
    logic         wr_ready;
    logic [31:0]  rd_addr;
    logic         fwd_hit;
    logic [255:0] fwd_data;
    logic         mem_req;
    logic [31:0]  mem_addr;
    logic [255:0] mem_wdata;
    logic         mem_ack;
    logic         flush;
    logic         busy;

    writeback_buf #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_valid  (wr_valid),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_ready  (wr_ready),
        .rd_addr   (rd_addr),
        .fwd_hit   (fwd_hit),
        .fwd_data  (fwd_data),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .flush     (flush),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state.
    logic [26:0]  m_tag [$];
    logic [255:0] m_dat [$];
    bit           m_infl;
    logic [287:0] exp_q [$];

    int n_vec;
    int n_err;
    bit mon_prev;
    logic [287:0] mon_cur;

    function automatic void chk(string nm, logic [255:0] act, logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    function automatic logic [255:0] rnd_blk();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom();
        return v;
    endfunction

    function automatic logic [31:0] rnd_addr();
        return 32'h0000_0100 + ($urandom_range(0, 7) << 5) + $urandom_range(0, 31);
    endfunction

    // One clock cycle: drive at negedge, check outputs, advance the model, return at next negedge.
    task automatic cyc(input bit wv, input logic [31:0] wa, input logic [255:0] wd,
                       input bit ack, input bit fl, input logic [31:0] ra);
        int j;
        bit exp_rdy;
        bit fh;
        logic [255:0] fd;
        bit start;
        wr_valid = wv; wr_addr = wa; wr_data = wd;
        mem_ack = ack; flush = fl; rd_addr = ra;
        #1;
        j = -1;
        for (int i = 0; i < m_tag.size(); i++)
            if (m_tag[i] == wa[31:5] && !(m_infl && i == 0)) j = i;
        exp_rdy = !fl && ((m_tag.size() < DEPTH) || (j >= 0));
        fh = 1'b0; fd = '0;
        for (int i = 0; i < m_tag.size(); i++)
            if (m_tag[i] == ra[31:5]) begin fh = 1'b1; fd = m_dat[i]; end
        chk("wr_ready", wr_ready, exp_rdy);
        chk("busy", busy, (m_tag.size() != 0) || m_infl);
        chk("fwd_hit", fwd_hit, fh);
        chk("fwd_data", fwd_data, fd);
        chk("mem_req", mem_req, m_infl);
        start = !m_infl && (m_tag.size() != 0);
        if (wv && exp_rdy) begin
            if (j >= 0) m_dat[j] = wd;
            else begin m_tag.push_back(wa[31:5]); m_dat.push_back(wd); end
        end
        if (m_infl && ack) begin
            void'(m_tag.pop_front()); void'(m_dat.pop_front()); m_infl = 1'b0;
        end else if (start) begin
            m_infl = 1'b1;
            exp_q.push_back({m_tag[0], 5'b0, m_dat[0]});
        end
        @(negedge clk);
    endtask

    task automatic idle(input bit ack);
        cyc(1'b0, rnd_addr(), rnd_blk(), ack, 1'b0, rnd_addr());
    endtask

    // Wait for the model head to go in flight, hold mem_ack low dly cycles, then ack.
    task automatic drain_one(input int dly);
        int b;
        b = 0;
        while (!m_infl && b < 20) begin idle(1'b1); b++; end
        if (!m_infl) chk("drain_start_timeout", 0, 1);
        repeat (dly) idle(1'b0);
        idle(1'b1);
    endtask

    // Scoreboard monitor: each new memory request pops one expected write, which must then stay stable.
    initial begin
        mon_prev = 1'b0;
        mon_cur  = '0;
        forever begin
            @(posedge clk);
            #2;
            if (rst) begin
                mon_prev = 1'b0;
            end else begin
                if (mem_req && !mon_prev) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_mem_req", 1, 0);
                        mon_cur = {mem_addr, mem_wdata};
                    end else begin
                        mon_cur = exp_q.pop_front();
                    end
                end
                if (mem_req) begin
                    chk("mem_addr", mem_addr, mon_cur[287:256]);
                    chk("mem_wdata", mem_wdata, mon_cur[255:0]);
                end
                mon_prev = mem_req;
            end
        end
    end

    initial begin
        logic [255:0] d1, d2;
        int b;
        n_vec = 0; n_err = 0; m_infl = 1'b0;
        rst = 1'b1; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
        rd_addr = '0; mem_ack = 1'b0; flush = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_wr_ready", wr_ready, 1);
        chk("rst_fwd_hit", fwd_hit, 0);
        chk("rst_fwd_data", fwd_data, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Single write, acknowledged 3 cycles into the request.
        d1 = rnd_blk();
        cyc(1'b1, 32'h40, d1, 1'b0, 1'b0, 32'h40);
        drain_one(2);
        idle(1'b0); idle(1'b0);

        // Fill with distinct blocks, stall a 5th, merge into a buffered non-head block.
        for (int i = 0; i < 4; i++) cyc(1'b1, 32'h200 + 32'(i) * 32, rnd_blk(), 1'b0, 1'b0, 32'h220);
        cyc(1'b1, 32'h280, rnd_blk(), 1'b0, 1'b0, 32'h240);
        cyc(1'b1, 32'h204, rnd_blk(), 1'b0, 1'b0, 32'h200);
        cyc(1'b1, 32'h24C, rnd_blk(), 1'b0, 1'b0, 32'h240);
        idle(1'b0);
        for (int i = 0; i < 4; i++) drain_one(i);

        // Two writes to one block before drain start: one memory write carrying D2.
        d1 = rnd_blk(); d2 = rnd_blk();
        cyc(1'b1, 32'h80, d1, 1'b0, 1'b0, 32'h80);
        cyc(1'b1, 32'h9C, d2, 1'b0, 1'b0, 32'h80);
        drain_one(1);
        idle(1'b0);

        // Write to a block already in flight: two memory writes, forwarding returns the newer one.
        d1 = rnd_blk(); d2 = rnd_blk();
        cyc(1'b1, 32'h80, d1, 1'b0, 1'b0, 32'h84);
        idle(1'b0);
        cyc(1'b1, 32'h80, d2, 1'b0, 1'b0, 32'h84);
        cyc(1'b0, 32'h0, '0, 1'b0, 1'b0, 32'h84);
        drain_one(0);
        drain_one(2);
        idle(1'b0);

        // Reset while the memory write is outstanding.
        cyc(1'b1, 32'h300, rnd_blk(), 1'b0, 1'b0, 32'h300);
        idle(1'b0); idle(1'b0);
        rd_addr = 32'h300;
        rst = 1'b1;
        #1;
        chk("rst_mid_mem_req", mem_req, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_fwd_hit", fwd_hit, 0);
        chk("rst_mid_wr_ready", wr_ready, 1);
        m_tag.delete(); m_dat.delete(); exp_q.delete(); m_infl = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) idle(1'b1);

        // Ten in-order writes through pointer wrap with random ack delays.
        for (int i = 0; i < 10; i++) begin
            b = 0;
            while (!(m_tag.size() < DEPTH) && b < 30) begin
                idle($urandom_range(0, 5) == 0); b++;
            end
            cyc(1'b1, 32'h1000 + 32'(i) * 32, rnd_blk(), $urandom_range(0, 5) == 0, 1'b0, rnd_addr());
        end

        // Random traffic over a small tag pool with occasional flush episodes.
        for (int i = 0; i < 400; i++) begin
            cyc($urandom_range(0, 1), rnd_addr(), rnd_blk(), $urandom_range(0, 2) == 0,
                (i % 100) >= 85, rnd_addr());
        end

        // Flush until drained; writes must be refused throughout.
        b = 0;
        while (((m_tag.size() != 0) || m_infl) && b < 200) begin
            cyc($urandom_range(0, 1), rnd_addr(), rnd_blk(), $urandom_range(0, 2) == 0, 1'b1, rnd_addr());
            b++;
        end
        if ((m_tag.size() != 0) || m_infl) chk("flush_drain_timeout", 0, 1);
        cyc(1'b1, rnd_addr(), rnd_blk(), 1'b0, 1'b1, rnd_addr());
        idle(1'b0); idle(1'b0);
        chk("scoreboard_left", 32'(exp_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
